// File: rtl/rx_cnt_pkg.sv
// Shared types and helpers for the RX frame counter.
//   rx_frame_state_t : frame FSM state encoding
//   sat_inc          : +1 on a counter of a given width; wraps by default and
//                      holds at all-ones when RX_CNT_SATURATE_EN is defined
package rx_cnt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_frame_state_t;

  // Widest counter sat_inc can handle; callers zero-extend into this width.
  localparam int unsigned SAT_W = 64;

  // Increment value (interpreted as a width-bit counter) when enable is set.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic              enable,
                                               input int unsigned       width);
    logic [SAT_W-1:0] max_val;
    max_val = (SAT_W'(1) << width) - SAT_W'(1);
    sat_inc = value;
    if (enable) begin
`ifdef RX_CNT_SATURATE_EN
      if (value != max_val) begin
        sat_inc = value + SAT_W'(1);
      end
`else
      sat_inc = (value + SAT_W'(1)) & max_val;
`endif
    end
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector.
//   clk, rst : clock, asynchronous active-low reset
//   d        : level input
//   pulse_c  : combinational pulse, high while d=1 and previous d=0
// RST_VAL sets the assumed previous level out of reset; 1 suppresses a pulse
// for an input that is already high when reset is released.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse_c
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d     = d;
    pulse_c = d & ~d_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q <= RST_VAL;
    end else begin
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/rx_frame_counter.sv
// RX byte/frame counter between UART RX and the matrix-load controller.
//   clk, rst    : clock, asynchronous active-low reset
//   clr         : synchronous clear of counters and FSM (highest priority)
//   rx_done     : byte-received strobe, counted once per rising edge
//   frame_len   : bytes per frame, sampled on the first byte (0 treated as 1)
//   byte_count  : total bytes since reset/clr
//   frame_count : completed frames since reset/clr
//   byte_idx    : bytes received in the current frame
//   busy        : high while a multi-byte frame is in progress
//   frame_done  : one-cycle pulse on frame completion
//   timeout     : one-cycle pulse when a frame stalls past TIMEOUT_CYC
// Build option: define RX_CNT_SATURATE_EN to make both counters saturate
// instead of wrapping.
module rx_frame_counter
  import rx_cnt_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             rx_done,
  input  logic [LEN_W-1:0] frame_len,
  output logic [CNT_W-1:0] byte_count,
  output logic [CNT_W-1:0] frame_count,
  output logic [LEN_W-1:0] byte_idx,
  output logic             busy,
  output logic             frame_done,
  output logic             timeout
);

  logic            ev_c;
  logic            expire_c;
  logic [LEN_W-1:0] len_eff_c;

  rx_frame_state_t  state_q,      state_d;
  logic [LEN_W-1:0] len_q,        len_d;
  logic [LEN_W-1:0] byte_idx_q,   byte_idx_d;
  logic [CNT_W-1:0] byte_cnt_q,   byte_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q,  frame_cnt_d;
  logic             busy_q,       busy_d;
  logic             frame_done_q, frame_done_d;
  logic             timeout_q,    timeout_d;

  // rx_done assumed high out of reset so a held strobe is not counted.
  rise_detect #(
    .RST_VAL(1'b1)
  ) u_rise (
    .clk    (clk),
    .rst    (rst),
    .d      (rx_done),
    .pulse_c(ev_c)
  );

  // Inter-byte watchdog; absent entirely when TIMEOUT_CYC is 0.
  if (TIMEOUT_CYC > 0) begin : g_timer
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;

    always_comb begin
      expire_c = (state_q == RECV) && !ev_c &&
                 (timer_q == TMR_W'(TIMEOUT_CYC - 1));
      timer_d  = timer_q + TMR_W'(1);
      if (clr || ev_c || (state_q != RECV) || expire_c) begin
        timer_d = '0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_d;
      end
    end
  end else begin : g_no_timer
    assign expire_c = 1'b0;
  end

  assign len_eff_c = (frame_len == '0) ? LEN_W'(1) : frame_len;

  // Next-state and counter update.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    byte_cnt_d   = byte_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    timeout_d    = 1'b0;

    if (clr) begin
      state_d     = IDLE;
      byte_idx_d  = '0;
      byte_cnt_d  = '0;
      frame_cnt_d = '0;
    end else begin
      byte_cnt_d = CNT_W'(sat_inc(SAT_W'(byte_cnt_q), ev_c, CNT_W));

      case (state_q)
        IDLE: begin
          byte_idx_d = '0;
          if (ev_c) begin
            if (len_eff_c == LEN_W'(1)) begin
              frame_done_d = 1'b1;
              frame_cnt_d  = CNT_W'(sat_inc(SAT_W'(frame_cnt_q), 1'b1, CNT_W));
            end else begin
              len_d      = len_eff_c;
              byte_idx_d = LEN_W'(1);
              state_d    = RECV;
            end
          end
        end
        RECV: begin
          // A byte arriving on the expiry cycle wins over the timeout.
          if (ev_c) begin
            if ((byte_idx_q + LEN_W'(1)) == len_q) begin
              frame_done_d = 1'b1;
              frame_cnt_d  = CNT_W'(sat_inc(SAT_W'(frame_cnt_q), 1'b1, CNT_W));
              byte_idx_d   = '0;
              state_d      = IDLE;
            end else begin
              byte_idx_d = byte_idx_q + LEN_W'(1);
            end
          end else if (expire_c) begin
            timeout_d  = 1'b1;
            byte_idx_d = '0;
            state_d    = IDLE;
          end
        end
        default: begin
          state_d    = IDLE;
          byte_idx_d = '0;
        end
      endcase
    end

    busy_d = (state_d == RECV);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      byte_idx_q   <= '0;
      byte_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign byte_count  = byte_cnt_q;
  assign frame_count = frame_cnt_q;
  assign byte_idx    = byte_idx_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/rx_frame_counter.md
Name: rx_frame_counter

Overview:
Parametrised successor to the single-channel RX byte counter. Counts rising edges of the UART receiver's rx_done strobe and keeps a running total. Also groups bytes into frames of software-programmed length, flagging completed frames and aborting frames that stall past an inter-byte timeout. Sits between the UART RX and the matrix-load controller, which uses frame_done to know when a full operand block has arrived.

Parameters:
CNT_W, 32, width of byte_count and frame_count
LEN_W, 16, width of frame_len and byte_idx
TIMEOUT_CYC, 100000, clk cycles without a byte inside a frame before abort; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
clr  in  1  synchronous clear of counters and FSM
rx_done  in  1  byte-received strobe from UART RX (level, any length)
frame_len  in  LEN_W  bytes per frame; sampled on first byte of each frame
byte_count  out  CNT_W  total bytes since reset/clr
frame_count  out  CNT_W  completed frames since reset/clr
byte_idx  out  LEN_W  bytes received in current frame
busy  out  1  high while in RECV
frame_done  out  1  one-cycle pulse, frame complete
timeout  out  1  one-cycle pulse, frame aborted

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk.
- Reset values: byte_count=0, frame_count=0, byte_idx=0, busy=0, frame_done=0, timeout=0, state=IDLE, idle timer=0.
- Reset value of rx_done_q is 1, so rx_done already high at reset release is not counted.
- Event detection: ev = rx_done & ~rx_done_q.
  - rx_done_q <= rx_done every cycle, including during clr.
  - One ev per low-to-high transition, however long rx_done stays high.
- Latency: ev sampled at edge N updates byte_count, byte_idx and frame_count at edge N. frame_done/timeout are registered and high for the single cycle after edge N.
- byte_count: +1 on every ev in any state. Wraps modulo 2^CNT_W (see optional feature).
- Effective length: len_eff = (frame_len==0) ? 1 : frame_len.
- FSM states:
  - IDLE: byte_idx=0, busy=0.
    - On ev with len_eff==1: frame_done, frame_count+1, stay IDLE.
    - On ev with len_eff>1: latch len_eff into len_q, byte_idx<=1, go to RECV.
  - RECV: busy=1.
    - On ev with byte_idx+1==len_q: frame_done, frame_count+1, byte_idx<=0, go to IDLE.
    - On any other ev: byte_idx+1.
- Timer:
  - Cleared on every ev and in IDLE; increments each RECV cycle without ev.
  - When timer reaches TIMEOUT_CYC-1 with no ev: timeout pulse, byte_idx<=0, go to IDLE.
  - byte_count keeps the bytes already counted; frame_count is unchanged.
  - Width is clog2(TIMEOUT_CYC+1). TIMEOUT_CYC=0 removes the timer entirely.
- Simultaneous ev and timer expiry: ev wins, timer clears, no timeout.
- frame_len changes mid-frame are ignored until the next frame starts.
- clr (highest priority, synchronous): zeroes byte_count, frame_count, byte_idx and the timer; state=IDLE; suppresses frame_done/timeout. An ev in the same cycle is dropped.
- rst asserted mid-frame: immediate return to reset values.

Optional Feature:
Macro RX_CNT_SATURATE_EN.
- Defined: byte_count and frame_count hold at 2^CNT_W-1 instead of wrapping; frame logic continues normally.
- Undefined: both counters wrap to 0.

Decomposition:
- Package rx_cnt_pkg:
  - typedef enum logic {IDLE, RECV} rx_frame_state_t
  - function sat_inc(value, enable) used by both counters
- Sub-module rise_detect: one-bit rising-edge detector with a reset-value parameter (here 1). Output is a combinational pulse; reusable for other strobes.

Test Plan:
- Hold rx_done=1 through reset release, then keep it high 10 cycles -> byte_count stays 0, no frame_done.
- frame_len=3; three rx_done pulses (first one 5 cycles wide) -> byte_idx 1,2,0; single frame_done after third; frame_count=1, byte_count=3.
- frame_len=0 and frame_len=1; one pulse each -> frame_done each time, busy never 1, frame_count=2.
- TIMEOUT_CYC=20, frame_len=4; two bytes then idle -> timeout pulse exactly 20 cycles after second ev; byte_idx=0, byte_count=2, frame_count=0. Next byte starts a fresh frame.
- clr asserted in the same cycle as an rx_done rising edge, mid-frame -> all counters 0, IDLE, no pulses; that byte is not counted.
- CNT_W=4, 17 single-byte frames -> byte_count=1 without the macro, 15 with RX_CNT_SATURATE_EN; same for frame_count.
